// File: rtl/apb3_master_arbiter.sv
// Two-requester round-robin arbiter driving a single APB3 master port (IDLE/SETUP/ACCESS).
// Optional ACCESS-phase timeout is compiled in with `define APB3_ARB_TIMEOUT_EN.
module apb3_master_arbiter #(
  parameter int N_BIT_DATA     = 32,
  parameter int N_BIT_ADDRESS  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  // Requester side: a requester holds req_i and its fields stable until its
  // done_o pulse; done_o/rdata_o/err_o are a one-cycle response, zero otherwise.
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 write_i,
  input  logic [2*N_BIT_ADDRESS-1:0] addr_i,
  input  logic [2*N_BIT_DATA-1:0]    wdata_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 done_o,
  output logic [N_BIT_DATA-1:0]      rdata_o,
  output logic                       err_o,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [N_BIT_ADDRESS-1:0]   PADDR,
  output logic [N_BIT_DATA-1:0]      PWDATA,
  input  logic [N_BIT_DATA-1:0]      PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR,
  output logic [1:0]                 state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                gnt_q, gnt_d;
  logic [1:0]                done_q, done_d;
  logic                      owner_q, owner_d;
  logic                      last_q, last_d;
  logic                      write_q, write_d;
  logic [N_BIT_ADDRESS-1:0]  addr_q, addr_d;
  logic [N_BIT_DATA-1:0]     wdata_q, wdata_d;
  logic [N_BIT_DATA-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [1:0]                elig;
  logic                      nxt;
  logic                      complete;
  logic                      start;
  logic                      timed_out;

`ifdef APB3_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q = ACCESS cycles already spent before the current one
  assign timed_out = (state_q == ACCESS) && !PREADY && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d     = ((state_q == ACCESS) && !complete) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    // A requester in its done cycle is still holding a stale request.
    elig     = req_i & ~done_q;
    complete = (state_q == ACCESS) && (PREADY || timed_out);
    nxt      = (state_q == IDLE) ? (elig[~last_q] ? ~last_q : last_q) : ~owner_q;
    start    = ((state_q == IDLE) && (|elig)) || (complete && elig[~owner_q]);

    case (state_q)
      IDLE:    state_d = IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (complete) begin
          done_d[owner_q] = 1'b1;
          rdata_d         = (PREADY && !write_q) ? PRDATA : '0;
          err_d           = PREADY ? PSLVERR : 1'b1;
          state_d         = IDLE;
          gnt_d           = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SETUP;
      owner_d = nxt;
      last_d  = nxt;
      gnt_d   = 2'b01 << nxt;
      write_d = write_i[nxt];
      addr_d  = addr_i[nxt*N_BIT_ADDRESS +: N_BIT_ADDRESS];
      wdata_d = wdata_i[nxt*N_BIT_DATA +: N_BIT_DATA];
    end
  end

  // last_q resets to 1 so requester 0 is favoured first.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign PSEL    = (state_q != IDLE);
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = write_q;
  assign PADDR   = addr_q;
  assign PWDATA  = wdata_q;
  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Bench for apb3_master_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; build with +define+APB3_ARB_TIMEOUT_EN for the timeout variant.
module tb_apb3_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int TO = 16;
`ifdef APB3_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [1:0]      req_i, write_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]      gnt_o, done_o;
  logic [DW-1:0]   rdata_o;
  logic            err_o;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA, PRDATA;
  logic            PREADY, PSLVERR;
  logic [1:0]      state_o;

  apb3_master_arbiter #(
    .N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_i(req_i), .write_i(write_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  bit            m_busy, m_access, m_wr, m_err;
  int            m_owner, m_last, m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_done;

  task automatic m_reset();
    m_busy = 0; m_access = 0; m_wr = 0; m_err = 0;
    m_owner = 0; m_last = 1; m_cnt = 0;
    m_addr = '0; m_wdata = '0; m_done = '0;
    exp_q.delete();
  endtask

  // One clock edge, using the inputs as they stood just before it.
  task automatic m_step();
    logic [1:0] elig;
    bit start;
    int nxt;
    elig   = req_i & ~m_done;
    m_done = '0;
    m_err  = 0;
    start  = 0;
    nxt    = 0;
    if (!m_busy) begin
      if (elig != 2'b00) begin
        start = 1;
        nxt   = elig[1 - m_last] ? 1 - m_last : m_last;
      end
    end else if (!m_access) begin
      m_access = 1;
      m_cnt    = 0;
    end else begin
      m_cnt++;
      if (PREADY || (TO_EN && m_cnt >= TO)) begin
        m_done[m_owner] = 1'b1;
        m_err = PREADY ? PSLVERR : 1'b1;
        exp_q.push_back((PREADY && !m_wr) ? PRDATA : '0);
        m_busy   = 0;
        m_access = 0;
        if (elig[1 - m_owner]) begin
          start = 1;
          nxt   = 1 - m_owner;
        end
      end
    end
    if (start) begin
      m_busy   = 1;
      m_access = 0;
      m_owner  = nxt;
      m_last   = nxt;
      m_wr     = write_i[nxt];
      m_addr   = addr_i[nxt*AW +: AW];
      m_wdata  = wdata_i[nxt*DW +: DW];
    end
  endtask

  task automatic check_outputs();
    chk("psel",    PSEL,    m_busy);
    chk("penable", PENABLE, m_busy & m_access);
    chk("pwrite",  PWRITE,  m_wr);
    chk("paddr",   PADDR,   m_addr);
    chk("pwdata",  PWDATA,  m_wdata);
    chk("gnt",     gnt_o,   m_busy ? 2'(1 << m_owner) : 2'b00);
    chk("done",    done_o,  m_done);
    chk("err",     err_o,   m_err);
    if (m_done != 2'b00 && exp_q.size() != 0) chk("rdata", rdata_o, exp_q.pop_front());
    else chk("rdata_quiet", rdata_o, '0);
  endtask

  // ---------------- drivers ----------------
  bit         rq_auto;
  int         slave_mode;  // 0: random slave, 1: slave inputs driven by hand
  logic [1:0] must_drop;

  task automatic drive_next();
    for (int k = 0; k < 2; k++) begin
      if (m_done[k]) begin
        // may linger through its own done cycle, must drop afterwards
        req_i[k]     = 1'($urandom_range(0, 1));
        must_drop[k] = 1'b1;
      end else if (must_drop[k]) begin
        req_i[k]     = 1'b0;
        must_drop[k] = 1'b0;
      end else if (rq_auto && !req_i[k] && $urandom_range(0, 3) == 0) begin
        req_i[k]              = 1'b1;
        write_i[k]            = 1'($urandom_range(0, 1));
        addr_i[k*AW +: AW]    = AW'($urandom());
        wdata_i[k*DW +: DW]   = DW'($urandom());
      end
    end
    if (slave_mode == 0) begin
      PREADY  = ($urandom_range(0, 2) != 0);
      PSLVERR = ($urandom_range(0, 3) == 0);
      PRDATA  = DW'($urandom());
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    if (!PRESET) m_step();
    #1;
    check_outputs();
    drive_next();
  endtask

  task automatic fresh_reset();
    PRESET = 1'b1;
    m_reset();
    req_i = '0;
    must_drop = '0;
    tick();
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic mid_reset();
    #2;
    PRESET = 1'b1;
    m_reset();
    #1;
    chk("rst_psel",    PSEL,    1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_done",    done_o,  2'b00);
    chk("rst_gnt",     gnt_o,   2'b00);
    tick();
    tick();
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int lat, t0, t1, to_at;
  bit saw_to;

  initial begin
    PRESET = 1'b1;
    req_i = '0; write_i = '0; addr_i = '0; wdata_i = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    rq_auto = 0; slave_mode = 1; must_drop = '0;
    m_reset();
    #1;
    check_outputs();
    @(negedge PCLK);
    PRESET = 1'b0;

    // single read, latency from request
    req_i = 2'b01; write_i = 2'b00; addr_i[0 +: AW] = 4'h3;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hDEADBEEF;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (done_o[0]) lat = i;
    end
    chk("read_latency", lat, 3);
    chk("read_data", rdata_o, 32'hDEADBEEF);
    chk("read_err", err_o, 1'b0);
    tick(); tick();

    // simultaneous writes after reset
    fresh_reset();
    req_i = 2'b11; write_i = 2'b11;
    addr_i = {4'h2, 4'h1}; wdata_i = {32'h22222222, 32'h11111111};
    PREADY = 1'b1; PSLVERR = 1'b0;
    t0 = 0; t1 = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done_o[0] && t0 == 0) t0 = i;
      if (done_o[1] && t1 == 0) t1 = i;
    end
    chk("b2b_first", t0, 3);
    chk("b2b_second", t1, 5);

    // wait states then slave error on a write
    req_i = 2'b01; write_i = 2'b01; addr_i[0 +: AW] = 4'h5; wdata_i[0 +: DW] = 32'hA5A55A5A;
    PREADY = 1'b0; PSLVERR = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 2) begin
        chk("stall_paddr", PADDR, 4'h5);
        chk("stall_pwdata", PWDATA, 32'hA5A55A5A);
      end
    end
    PREADY = 1'b1; PSLVERR = 1'b1;
    tick();
    chk("slverr_done", done_o, 2'b01);
    chk("slverr_err", err_o, 1'b1);
    PSLVERR = 1'b0;
    tick();

    // reset in the middle of ACCESS
    req_i = 2'b10; write_i = 2'b00; addr_i[AW +: AW] = 4'h9; PREADY = 1'b0;
    tick(); tick();
    chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    mid_reset();
    PREADY = 1'b1; PRDATA = 32'h0BADF00D;
    tick();
    chk("fresh_setup", {PSEL, PENABLE}, 2'b10);
    tick(); tick();
    chk("fresh_done", done_o, 2'b10);
    tick();

    // slave that never answers
    req_i = 2'b01; write_i = 2'b00; addr_i[0 +: AW] = 4'hC; PREADY = 1'b0;
    saw_to = 0; to_at = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done_o[0] && !saw_to) begin
        saw_to = 1;
        to_at  = i;
        chk("to_err", err_o, 1'b1);
        chk("to_rdata", rdata_o, '0);
      end
    end
`ifdef APB3_ARB_TIMEOUT_EN
    chk("timeout_seen", saw_to, 1'b1);
    chk("timeout_cycle", to_at, 2 + TO);
`else
    chk("no_timeout", saw_to, 1'b0);
    chk("still_access", {PSEL, PENABLE}, 2'b11);
`endif
    PREADY = 1'b1;
    tick(); tick(); tick();

    // random traffic with occasional asynchronous resets
    fresh_reset();
    rq_auto = 1; slave_mode = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) mid_reset();
    end
    rq_auto = 0;
    repeat (30) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
